fetch_unit: RTL and testbench

Instruction fetch stage of the CPU: reads 16-bit instruction words from the 8-bit memory bus as two byte transfers, low byte first. It presents each complete word, with its address, to the decoder and execute logic over a valid/ready handshake. It owns the program counter and accepts absolute jump redirects from the execute stage. The decoder consumes `word` directly.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Two-byte instruction fetch from an 8-bit bus, valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic [15:0] word,
    output logic [15:0] word_pc,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [15:0] pc,
    input  logic        jump,
    input  logic [15:0] jump_addr
);

    localparam logic [15:0] C_RESET_PC = RESET_PC & 16'hFFFE;

    typedef enum logic [1:0] {
        START    = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [7:0]  r_lo_byte;
    logic        w_take_jump;

    assign w_take_jump = jump && (r_state != START);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= START;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            START:    w_next_state = FETCH_LO;
            FETCH_LO: if (mem_ready)  w_next_state = FETCH_HI;
            FETCH_HI: if (mem_ready)  w_next_state = HOLD;
            HOLD:     if (word_ready) w_next_state = FETCH_LO;
            default:  w_next_state = START;
        endcase
        // A redirect overrides any transfer or pending word.
        if (w_take_jump) begin
            w_next_state = FETCH_LO;
        end
    end

    // Low byte is staged separately so the presented word only changes on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= C_RESET_PC;
            r_lo_byte <= 8'h00;
            word      <= 16'h0000;
            word_pc   <= 16'h0000;
        end else if (w_take_jump) begin
            r_pc      <= jump_addr & 16'hFFFE;
            r_lo_byte <= 8'h00;
        end else begin
            case (r_state)
                FETCH_LO: begin
                    if (mem_ready) begin
                        r_lo_byte <= mem_data;
                    end
                end
                FETCH_HI: begin
                    if (mem_ready) begin
                        word    <= {mem_data, r_lo_byte};
                        word_pc <= r_pc;
                        r_pc    <= r_pc + 16'd2;
                    end
                end
                default: begin
                    r_lo_byte <= r_lo_byte;
                end
            endcase
        end
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_addr   = 16'h0000;
        word_valid = 1'b0;
        case (r_state)
            FETCH_LO: begin
                mem_rd   = 1'b1;
                mem_addr = r_pc;
            end
            FETCH_HI: begin
                mem_rd   = 1'b1;
                mem_addr = r_pc | 16'h0001;
            end
            HOLD: begin
                word_valid = 1'b1;
            end
            default: begin
                mem_rd = 1'b0;
            end
        endcase
    end

    assign pc = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit with a wait-state memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic [15:0] word;
    logic [15:0] word_pc;
    logic        word_valid;
    logic        word_ready;
    logic [15:0] pc;
    logic        jump;
    logic [15:0] jump_addr;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          ws;
    int          last_cyc;
    bit          have_last;
    bit          stream_chk;
    logic [31:0] sb_q[$];

    fetch_unit #(.RESET_PC(16'h0100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .word       (word),
        .word_pc    (word_pc),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .pc         (pc),
        .jump       (jump),
        .jump_addr  (jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a == 16'h0100) return 8'h3C;
        if (a == 16'h0101) return 8'hA5;
        return a[7:0] + (a[15:8] * 8'd3) + 8'h11;
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {mem_byte(a | 16'h0001), mem_byte(a & 16'hFFFE)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [15:0] a);
        sb_q.push_back({a, mem_word(a)});
    endtask

    task automatic drain();
        int b;
        b = 0;
        word_ready = 1'b1;
        while (sb_q.size() != 0 && b < 100) begin
            step(1);
            b++;
        end
        chk("drain_timeout", sb_q.size(), 0);
        word_ready = 1'b0;
    endtask

    // Memory model: ws wait cycles before each byte is ready.
    initial begin
        int          cnt;
        logic [15:0] last_addr;
        bit          last_ok;
        cnt = 0; last_ok = 1'b0; last_addr = 16'h0;
        mem_ready = 1'b0; mem_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_rd) begin
                cnt = 0;
                last_ok = 1'b0;
                mem_ready = (ws == 0);
            end else begin
                if (!last_ok || mem_addr != last_addr) cnt = 0;
                last_ok = 1'b1;
                last_addr = mem_addr;
                mem_ready = (cnt >= ws);
                cnt++;
            end
            mem_data = mem_byte(mem_addr);
        end
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard monitor: a handshake happens on the edge after this sample.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && word_valid && word_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_word_pc", {16'h0, word_pc}, {16'h0, e[31:16]});
                    chk("sb_word", {16'h0, word}, {16'h0, e[15:0]});
                end
                if (stream_chk) begin
                    if (have_last) chk("stream_period", cyc - last_cyc, 3);
                    have_last = 1'b1;
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin
        int n;
        n_vec = 0; n_err = 0; ws = 0;
        have_last = 1'b0; stream_chk = 1'b0;
        rst_n = 1'b0; word_ready = 1'b0; jump = 1'b0; jump_addr = 16'h0;

        // Reset state and first fetch
        step(3);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_pc", pc, 16'h0100);
        chk("rst_word", word, 16'h0);
        chk("rst_word_pc", word_pc, 16'h0);
        push_exp(16'h0100);
        rst_n = 1'b1;
        step(1);
        chk("first_rd", mem_rd, 1);
        chk("first_addr_lo", mem_addr, 16'h0100);
        step(1);
        chk("first_addr_hi", mem_addr, 16'h0101);
        chk("first_valid_early", word_valid, 0);
        step(1);
        chk("first_valid", word_valid, 1);
        chk("first_word", word, 16'hA53C);
        chk("first_word_pc", word_pc, 16'h0100);
        chk("first_pc", pc, 16'h0102);
        step(5);
        chk("hold_valid", word_valid, 1);
        chk("hold_word", word, 16'hA53C);
        chk("hold_rd", mem_rd, 0);
        drain();

        // Jump in HOLD without acceptance drops the word
        step(2);
        chk("hold_pre_jump", word_valid, 1);
        jump = 1'b1; jump_addr = 16'h0000;
        step(1);
        jump = 1'b0;
        chk("jump_drop_valid", word_valid, 0);
        chk("jump_target_addr", mem_addr, 16'h0000);
        chk("jump_target_rd", mem_rd, 1);

        // Streaming from 0x0000
        for (int i = 0; i < 5; i++) push_exp(16'(2 * i));
        stream_chk = 1'b1; have_last = 1'b0;
        word_ready = 1'b1;
        step(2);
        chk("jump_target_valid", word_valid, 1);
        drain();
        stream_chk = 1'b0;

        // Wait states: two idle cycles per byte
        rst_n = 1'b0;
        ws = 2;
        step(2);
        push_exp(16'h0100);
        rst_n = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
            if (n <= 6) begin
                chk("ws_addr", mem_addr, (n <= 3) ? 16'h0100 : 16'h0101);
                chk("ws_rd", mem_rd, 1);
            end
        end while (!word_valid && n < 20);
        chk("ws_edges", n, 7);
        drain();
        ws = 0;

        // Wrap-around at the top of memory
        push_exp(16'hFFFE);
        push_exp(16'h0000);
        jump = 1'b1; jump_addr = 16'hFFFE;
        step(1);
        jump = 1'b0;
        chk("wrap_addr_lo", mem_addr, 16'hFFFE);
        step(1);
        chk("wrap_addr_hi", mem_addr, 16'hFFFF);
        step(1);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_word_pc", word_pc, 16'hFFFE);
        drain();

        // Jump while in FETCH_HI with a coincident mem_ready
        step(1);
        chk("mid_state_hi", mem_addr, 16'h0003);
        jump = 1'b1; jump_addr = 16'h0041;
        step(1);
        jump = 1'b0;
        chk("mid_jump_addr", mem_addr, 16'h0040);
        chk("mid_jump_pc", pc, 16'h0040);
        chk("mid_jump_valid", word_valid, 0);
        chk("mid_word_kept", word, mem_word(16'h0000));
        chk("mid_word_pc_kept", word_pc, 16'h0000);
        push_exp(16'h0040);
        drain();

        // Asynchronous reset during FETCH_HI
        step(1);
        chk("arst_pre_hi", mem_addr, 16'h0043);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_rd", mem_rd, 0);
        chk("arst_valid", word_valid, 0);
        chk("arst_addr", mem_addr, 16'h0);
        chk("arst_pc", pc, 16'h0100);
        chk("arst_word", word, 16'h0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("arst_refetch_word", word, 16'hA53C);
        chk("sb_leftover", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
